// File: rtl/acoustics_pkg.sv
// Shared helpers for the acoustics acquisition path: channel-select width,
// sign-aware compare and per-mode clear value.
package acoustics_pkg;

   localparam int CMP_W = 64;

   function automatic int ch_sel_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Operands arrive zero-extended; flipping bit w-1 maps two's complement
   // order onto unsigned order, so one comparator serves both modes.
   function automatic logic gt_sel(input logic [CMP_W-1:0] a,
                                   input logic [CMP_W-1:0] b,
                                   input int               w,
                                   input logic             signed_mode);
      logic [CMP_W-1:0] bias;
      bias = signed_mode ? (CMP_W'(1) << (w - 1)) : '0;
      return (a ^ bias) > (b ^ bias);
   endfunction

   function automatic logic [CMP_W-1:0] clear_val(input int w, input logic signed_mode);
      return signed_mode ? (CMP_W'(1) << (w - 1)) : '0;
   endfunction

endpackage

// File: rtl/peak_lane.sv
// One channel of the peak tracker: running max/index/count/seen state and
// the snapshot registers loaded on each window boundary.
module peak_lane
   import acoustics_pkg::*;
#(
   parameter int DATA_W      = 10,
   parameter int IDX_W       = 12,
   parameter int SEL_W       = 2,
   parameter int CH          = 0,
   parameter int SIGNED_MODE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [SEL_W-1:0]  sample_ch,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              window_end,
   output logic [DATA_W-1:0] snap_value,
   output logic [IDX_W-1:0]  snap_index,
   output logic              snap_seen
);

   localparam logic [DATA_W-1:0] CLR_VAL = DATA_W'(clear_val(DATA_W, SIGNED_MODE != 0));

   logic [DATA_W-1:0] run_max, nxt_max;
   logic [IDX_W-1:0]  run_idx, nxt_idx;
   logic [IDX_W-1:0]  cnt, nxt_cnt;
   logic              seen, nxt_seen;
   logic              accept;
   logic              gt;

   // sample_valid qualifies sample_ch/sample_data for exactly one cycle; there
   // is no ready, every valid sample addressed to this lane is taken.
   assign accept = sample_valid && (sample_ch == SEL_W'(CH));
   assign gt     = gt_sel(CMP_W'(sample_data), CMP_W'(run_max), DATA_W, SIGNED_MODE != 0);

   always_comb begin
      nxt_max  = run_max;
      nxt_idx  = run_idx;
      nxt_cnt  = cnt;
      nxt_seen = seen;
      if (accept) begin
         // Strict compare keeps the earliest index on ties.
         if (!seen || gt) begin
            nxt_max = sample_data;
            nxt_idx = cnt;
         end
         if (cnt != '1) begin
            nxt_cnt = cnt + 1'b1;
         end
         nxt_seen = 1'b1;
      end
   end

   // Reset zeroes run_max even in signed mode; seen=0 forces the first load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_max    <= '0;
         run_idx    <= '0;
         cnt        <= '0;
         seen       <= 1'b0;
         snap_value <= '0;
         snap_index <= '0;
         snap_seen  <= 1'b0;
      end else if (window_end) begin
         snap_value <= nxt_seen ? nxt_max : CLR_VAL;
         snap_index <= nxt_seen ? nxt_idx : '0;
         snap_seen  <= nxt_seen;
         run_max    <= CLR_VAL;
         run_idx    <= '0;
         cnt        <= '0;
         seen       <= 1'b0;
      end else begin
         run_max <= nxt_max;
         run_idx <= nxt_idx;
         cnt     <= nxt_cnt;
         seen    <= nxt_seen;
      end
   end

endmodule

// File: rtl/channel_peak_tracker.sv
// Multi-channel windowed peak detector: per-channel lanes plus the
// result_valid pulse and packing of the snapshot buses (ch0 in LSBs).
module channel_peak_tracker
   import acoustics_pkg::*;
#(
   parameter int DATA_W      = 10,
   parameter int NUM_CH      = 4,
   parameter int IDX_W       = 12,
   parameter int SIGNED_MODE = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sample_valid,
   input  logic [ch_sel_w(NUM_CH)-1:0]   sample_ch,
   input  logic [DATA_W-1:0]             sample_data,
   input  logic                          window_end,
   output logic [NUM_CH*DATA_W-1:0]      peak_value,
   output logic [NUM_CH*IDX_W-1:0]       peak_index,
   output logic [NUM_CH-1:0]             ch_seen,
   output logic                          result_valid
);

   localparam int SEL_W = ch_sel_w(NUM_CH);

   // Channel numbers >= NUM_CH match no lane and are dropped there.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      peak_lane #(
         .DATA_W      (DATA_W),
         .IDX_W       (IDX_W),
         .SEL_W       (SEL_W),
         .CH          (c),
         .SIGNED_MODE (SIGNED_MODE)
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .sample_valid (sample_valid),
         .sample_ch    (sample_ch),
         .sample_data  (sample_data),
         .window_end   (window_end),
         .snap_value   (peak_value[c*DATA_W +: DATA_W]),
         .snap_index   (peak_index[c*IDX_W +: IDX_W]),
         .snap_seen    (ch_seen[c])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_valid <= 1'b0;
      end else begin
         result_valid <= window_end;
      end
   end

endmodule

// File: tb/tb_channel_peak_tracker.sv
// Bench for channel_peak_tracker: an unsigned 4-channel instance and a signed
// 3-channel instance with a 3-bit index share one stimulus stream.
module tb_channel_peak_tracker;

   localparam int DW = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [1:0]  sample_ch;
   logic [9:0]  sample_data;
   logic        window_end;

   logic [39:0] peak_value_u;
   logic [47:0] peak_index_u;
   logic [3:0]  ch_seen_u;
   logic        result_valid_u;
   logic [29:0] peak_value_s;
   logic [8:0]  peak_index_s;
   logic [2:0]  ch_seen_s;
   logic        result_valid_s;

   logic [91:0] snap_u;
   logic [41:0] snap_s;
   assign snap_u = {ch_seen_u, peak_index_u, peak_value_u};
   assign snap_s = {ch_seen_s, peak_index_s, peak_value_s};

   int n_vec = 0;
   int n_err = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   channel_peak_tracker #(.DATA_W(10), .NUM_CH(4), .IDX_W(12), .SIGNED_MODE(0)) u_uns (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ch(sample_ch),
      .sample_data(sample_data), .window_end(window_end), .peak_value(peak_value_u),
      .peak_index(peak_index_u), .ch_seen(ch_seen_u), .result_valid(result_valid_u));

   channel_peak_tracker #(.DATA_W(10), .NUM_CH(3), .IDX_W(3), .SIGNED_MODE(1)) u_sgn (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ch(sample_ch),
      .sample_data(sample_data), .window_end(window_end), .peak_value(peak_value_s),
      .peak_index(peak_index_s), .ch_seen(ch_seen_s), .result_valid(result_valid_s));

   // ---------------- reference model / scoreboard ----------------
   int          win_q[4][$];
   logic [91:0] exp_u_q[$];
   logic [41:0] exp_s_q[$];
   logic [91:0] hold_u;
   logic [41:0] hold_s;
   bit          exp_rv;

   function automatic int sval(input int d, input bit sgn);
      return (sgn && d >= 512) ? d - 1024 : d;
   endfunction

   // Peak of the window's sample list: first occurrence of the largest value,
   // its position clipped to the largest representable index.
   function automatic void lane_ref(input int ch, input bit sgn, input int max_idx,
                                    output logic [9:0] v, output int idx, output bit seen);
      int best;
      if (win_q[ch].size() == 0) begin
         v = sgn ? 10'h200 : 10'h000;
         idx = 0;
         seen = 1'b0;
      end else begin
         best = win_q[ch][0];
         idx = 0;
         for (int k = 1; k < win_q[ch].size(); k++) begin
            if (sval(win_q[ch][k], sgn) > sval(best, sgn)) begin
               best = win_q[ch][k];
               idx = (k > max_idx) ? max_idx : k;
            end
         end
         v = 10'(best);
         seen = 1'b1;
      end
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) win_q[c].delete();
      exp_u_q.delete();
      exp_s_q.delete();
      hold_u = '0;
      hold_s = '0;
      exp_rv = 1'b0;
   endtask

   // ---------------- driver ----------------
   task automatic apply(input bit v, input int ch, input int d, input bit we);
      logic [91:0] eu;
      logic [41:0] es;
      logic [9:0]  pv;
      int          pi;
      bit          ps;
      sample_valid = v;
      sample_ch    = 2'(ch);
      sample_data  = 10'(d);
      window_end   = we;
      exp_rv       = we;
      if (v) win_q[ch].push_back(d & 1023);
      if (we) begin
         eu = '0;
         es = '0;
         for (int c = 0; c < 4; c++) begin
            lane_ref(c, 1'b0, 4095, pv, pi, ps);
            eu[c*10 +: 10] = pv;
            eu[40 + c*12 +: 12] = 12'(pi);
            eu[88 + c] = ps;
         end
         for (int c = 0; c < 3; c++) begin
            lane_ref(c, 1'b1, 7, pv, pi, ps);
            es[c*10 +: 10] = pv;
            es[30 + c*3 +: 3] = 3'(pi);
            es[39 + c] = ps;
         end
         exp_u_q.push_back(eu);
         exp_s_q.push_back(es);
         for (int c = 0; c < 4; c++) win_q[c].delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      apply(0, 0, 0, 0);
      model_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if (snap_u !== '0 || result_valid_u !== 1'b0) begin
         n_err++; $display("FAIL reset_u: got %h/%b want 0/0", snap_u, result_valid_u);
      end
      n_vec++;
      if (snap_s !== '0 || result_valid_s !== 1'b0) begin
         n_err++; $display("FAIL reset_s: got %h/%b want 0/0", snap_s, result_valid_s);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int vals[4] = '{5, 9, 9, 3};
      foreach (vals[i]) begin
         @(negedge clk); apply(1, 1, vals[i], 0);
      end
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (result_valid_u !== 1'b1 || result_valid_s !== 1'b1) begin
         n_err++; $display("FAIL basic_rv: got %b/%b want 1/1", result_valid_u, result_valid_s);
      end
      n_vec++;
      if (peak_value_u[19:10] !== 10'd9 || peak_index_u[23:12] !== 12'd1 || ch_seen_u !== 4'b0010) begin
         n_err++; $display("FAIL basic_ch1: got %0d/%0d/%b want 9/1/0010",
                           peak_value_u[19:10], peak_index_u[23:12], ch_seen_u);
      end
      n_vec++;
      if (snap_u !== hold_u) begin
         n_err++; $display("FAIL basic_snap_u: got %h want %h", snap_u, hold_u);
      end
      n_vec++;
      if (snap_s !== hold_s) begin
         n_err++; $display("FAIL basic_snap_s: got %h want %h", snap_s, hold_s);
      end
      apply(0, 0, 0, 0);
      @(negedge clk);
      n_vec++;
      if (result_valid_u !== 1'b0 || result_valid_s !== 1'b0) begin
         n_err++; $display("FAIL basic_rv_pulse: got %b/%b want 0/0", result_valid_u, result_valid_s);
      end
   endtask

   task automatic test_signed();
      int vals[3] = '{924, 1021, 974};  // -100, -3, -50
      foreach (vals[i]) begin
         @(negedge clk); apply(1, 0, vals[i], 0);
      end
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (peak_value_s[9:0] !== 10'h3FD || peak_index_s[2:0] !== 3'd1) begin
         n_err++; $display("FAIL signed_ch0: got %h/%0d want 3fd/1", peak_value_s[9:0], peak_index_s[2:0]);
      end
      n_vec++;
      if (peak_value_s[19:10] !== 10'h200 || peak_index_s[5:3] !== 3'd0 || ch_seen_s !== 3'b001) begin
         n_err++; $display("FAIL signed_unseen: got %h/%0d/%b want 200/0/001",
                           peak_value_s[19:10], peak_index_s[5:3], ch_seen_s);
      end
      n_vec++;
      if (snap_u !== hold_u) begin
         n_err++; $display("FAIL signed_snap_u: got %h want %h", snap_u, hold_u);
      end
      n_vec++;
      if (snap_s !== hold_s) begin
         n_err++; $display("FAIL signed_snap_s: got %h want %h", snap_s, hold_s);
      end
      apply(0, 0, 0, 0);
   endtask

   task automatic test_coincident();
      @(negedge clk); apply(1, 2, 300, 0);
      @(negedge clk); apply(1, 2, 700, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (peak_value_u[29:20] !== 10'd700 || peak_index_u[35:24] !== 12'd1) begin
         n_err++; $display("FAIL coincide_closing: got %0d/%0d want 700/1",
                           peak_value_u[29:20], peak_index_u[35:24]);
      end
      n_vec++;
      if (snap_s !== hold_s) begin
         n_err++; $display("FAIL coincide_snap_s: got %h want %h", snap_s, hold_s);
      end
      apply(1, 2, 50, 0);
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (peak_value_u[29:20] !== 10'd50 || peak_index_u[35:24] !== 12'd0 || ch_seen_u !== 4'b0100) begin
         n_err++; $display("FAIL coincide_next: got %0d/%0d/%b want 50/0/0100",
                           peak_value_u[29:20], peak_index_u[35:24], ch_seen_u);
      end
      n_vec++;
      if (snap_s !== hold_s) begin
         n_err++; $display("FAIL coincide_next_s: got %h want %h", snap_s, hold_s);
      end
      apply(0, 0, 0, 0);
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); apply(1, 2, 10 * (k + 1), 0);
      end
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (peak_value_s[29:20] !== 10'd100 || peak_index_s[8:6] !== 3'd7) begin
         n_err++; $display("FAIL sat_s: got %0d/%0d want 100/7", peak_value_s[29:20], peak_index_s[8:6]);
      end
      n_vec++;
      if (peak_value_u[29:20] !== 10'd100 || peak_index_u[35:24] !== 12'd9) begin
         n_err++; $display("FAIL sat_u: got %0d/%0d want 100/9", peak_value_u[29:20], peak_index_u[35:24]);
      end
      n_vec++;
      if (snap_s !== hold_s || snap_u !== hold_u) begin
         n_err++; $display("FAIL sat_snap: got %h %h want %h %h", snap_u, snap_s, hold_u, hold_s);
      end
      apply(0, 0, 0, 0);
   endtask

   // Channel 3 is out of range for the 3-channel instance.
   task automatic test_back_to_back();
      @(negedge clk); apply(1, 0, 20, 0);
      @(negedge clk); apply(1, 3, 77, 0);
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (ch_seen_u !== 4'b1001 || ch_seen_s !== 3'b001) begin
         n_err++; $display("FAIL b2b_first_seen: got %b/%b want 1001/001", ch_seen_u, ch_seen_s);
      end
      n_vec++;
      if (snap_u !== hold_u || snap_s !== hold_s) begin
         n_err++; $display("FAIL b2b_first: got %h %h want %h %h", snap_u, snap_s, hold_u, hold_s);
      end
      apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (result_valid_u !== 1'b1 || ch_seen_u !== 4'b0000 || ch_seen_s !== 3'b000) begin
         n_err++; $display("FAIL b2b_second: got rv=%b seen=%b/%b want 1 0000/000",
                           result_valid_u, ch_seen_u, ch_seen_s);
      end
      n_vec++;
      if (snap_u !== hold_u || snap_s !== hold_s) begin
         n_err++; $display("FAIL b2b_second_snap: got %h %h want %h %h", snap_u, snap_s, hold_u, hold_s);
      end
      apply(0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_window();
      @(negedge clk); apply(1, 1, 300, 0);
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (snap_u !== hold_u || snap_s !== hold_s) begin
         n_err++; $display("FAIL rst_pre: got %h %h want %h %h", snap_u, snap_s, hold_u, hold_s);
      end
      apply(1, 0, 99, 0);
      reset = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if (snap_u !== '0 || snap_s !== '0 || result_valid_u !== 1'b0 || result_valid_s !== 1'b0) begin
         n_err++; $display("FAIL rst_async: got %h %h rv=%b%b want all 0", snap_u, snap_s,
                           result_valid_u, result_valid_s);
      end
      @(negedge clk); apply(0, 0, 0, 0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); apply(1, 0, 1, 0);
      @(negedge clk); apply(0, 0, 0, 1);
      @(negedge clk);
      hold_u = exp_u_q.pop_front();
      hold_s = exp_s_q.pop_front();
      n_vec++;
      if (ch_seen_u !== 4'b0001 || peak_value_u[9:0] !== 10'd1 || ch_seen_s !== 3'b001) begin
         n_err++; $display("FAIL rst_after: got %b/%0d/%b want 0001/1/001",
                           ch_seen_u, peak_value_u[9:0], ch_seen_s);
      end
      n_vec++;
      if (snap_u !== hold_u || snap_s !== hold_s) begin
         n_err++; $display("FAIL rst_after_snap: got %h %h want %h %h", snap_u, snap_s, hold_u, hold_s);
      end
      apply(0, 0, 0, 0);
   endtask

   // Random traffic; every cycle checks the pulse and that snapshots hold.
   task automatic test_random();
      bit v, we;
      int ch, d;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         n_vec++;
         if (result_valid_u !== exp_rv || result_valid_s !== exp_rv) begin
            n_err++; $display("FAIL rand_rv @%0d: got %b/%b want %b", n, result_valid_u, result_valid_s, exp_rv);
         end
         if (exp_rv && exp_u_q.size() != 0) begin
            hold_u = exp_u_q.pop_front();
            hold_s = exp_s_q.pop_front();
         end
         n_vec++;
         if (snap_u !== hold_u) begin
            n_err++; $display("FAIL rand_snap_u @%0d: got %h want %h", n, snap_u, hold_u);
         end
         n_vec++;
         if (snap_s !== hold_s) begin
            n_err++; $display("FAIL rand_snap_s @%0d: got %h want %h", n, snap_s, hold_s);
         end
         v  = ($urandom_range(0, 3) != 0);
         ch = $urandom_range(0, 3);
         d  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1023) : $urandom_range(505, 518);
         we = ($urandom_range(0, 24) == 0);
         apply(v, ch, d, we);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_coincident();
      test_saturation();
      test_back_to_back();
      test_reset_mid_window();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
